// File: rtl/lfsr_pkg.sv
// Shared types and the LFSR step function used by both the generator and the checker,
// so the two ends of a link always agree on the polynomial.
package lfsr_pkg;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  localparam int unsigned LFSR_MAX_W = 32;

  // Returns {next_state, fb}; state and taps are zero-extended, bits above width are ignored.
  function automatic logic [LFSR_MAX_W:0] lfsr_next(
    input logic [LFSR_MAX_W-1:0] state,
    input logic [LFSR_MAX_W-1:0] taps,
    input int unsigned           width
  );
    logic                  fb;
    logic [LFSR_MAX_W-1:0] mask;
    mask = (width >= LFSR_MAX_W) ? '1 : ((LFSR_MAX_W'(1) << width) - LFSR_MAX_W'(1));
    fb   = ^(taps & state & mask);
    return {({state[LFSR_MAX_W-2:0], fb} & mask), fb};
  endfunction

endpackage

// File: rtl/lfsr_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// PRBS receive checker: seeds a shadow LFSR from the incoming stream, verifies it,
// then free-runs the shadow and counts mismatching bits while locked.
//
// state  | meaning
// SEED   | shifting received bits into the shadow until it holds WIDTH of them
// VERIFY | shadow still loads received bits; counting consecutive correct predictions
// LOCKED | shadow advances on its own prediction; mismatches are counted as bit errors
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH      = 5,
  parameter int unsigned LOCK_COUNT = 8,
  parameter int unsigned LOSS_COUNT = 4,
  parameter int unsigned ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             resync,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic [WIDTH-1:0] taps,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] shadow_state
);

  localparam int FILL_W  = $clog2(WIDTH + 1);
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int LOSS_W  = $clog2(LOSS_COUNT + 1);

  chk_state_e          state_q, state_d;
  logic [WIDTH-1:0]    shadow_q, shadow_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [MATCH_W-1:0]  match_q, match_d;
  logic [LOSS_W-1:0]   loss_q, loss_d;
  logic                locked_q;
  logic                pulse_q, pulse_d;
  logic                err_inc;
  logic                clear;

  logic [LFSR_MAX_W:0] nxt_full;
  logic [WIDTH-1:0]    shadow_adv;
  logic                pred;

  assign clear      = rst | resync;
  assign nxt_full   = lfsr_next(LFSR_MAX_W'(shadow_q), LFSR_MAX_W'(taps), WIDTH);
  assign shadow_adv = nxt_full[WIDTH:1];
  assign pred       = nxt_full[0];

  if (WIDTH < LFSR_MAX_W) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^nxt_full[LFSR_MAX_W:WIDTH+1];
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    fill_d   = fill_q;
    match_d  = match_q;
    loss_d   = loss_q;
    pulse_d  = 1'b0;
    err_inc  = 1'b0;
    if (in_valid) begin
      case (state_q)
        SEED: begin
          shadow_d = {shadow_q[WIDTH-2:0], in_bit};
          if (fill_q == FILL_W'(WIDTH - 1)) begin
            // An all-zero fill is a stuck state, so keep filling rather than verifying it.
            fill_d = '0;
            if (shadow_d != '0) begin
              state_d = VERIFY;
              match_d = '0;
            end
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end
        VERIFY: begin
          shadow_d = {shadow_q[WIDTH-2:0], in_bit};
          if (in_bit == pred) begin
            if (match_q == MATCH_W'(LOCK_COUNT - 1)) begin
              state_d = LOCKED;
              match_d = '0;
              loss_d  = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            state_d = SEED;
            fill_d  = '0;
            match_d = '0;
          end
        end
        LOCKED: begin
          // Free-run on the prediction so an isolated bad bit cannot poison later predictions.
          shadow_d = shadow_adv;
          if (in_bit != pred) begin
            pulse_d = 1'b1;
            err_inc = 1'b1;
            if (loss_q == LOSS_W'(LOSS_COUNT - 1)) begin
              state_d = SEED;
              loss_d  = '0;
              fill_d  = '0;
            end else begin
              loss_d = loss_q + 1'b1;
            end
          end else begin
            loss_d = '0;
          end
        end
        default: state_d = SEED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q  <= SEED;
      shadow_q <= '0;
      fill_q   <= '0;
      match_q  <= '0;
      loss_q   <= '0;
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
      loss_q   <= loss_d;
      locked_q <= (state_d == LOCKED);
      pulse_q  <= pulse_d;
    end
  end

  sat_counter #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk  (clk),
    .clr  (clear),
    .inc  (err_inc),
    .count(err_count)
  );

  assign locked       = locked_q;
  assign err_pulse    = pulse_q;
  assign shadow_state = shadow_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: driver pushes the expected post-edge outputs per cycle,
// a negedge monitor pops and compares them. ERR_W=3 so counter saturation is reachable.
module tb_lfsr_checker;

  localparam int WIDTH = 5;
  localparam int ERR_W = 3;

  logic             clk = 1'b0;
  logic             rst, resync, in_valid, in_bit;
  logic [WIDTH-1:0] taps;
  logic             locked, err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [WIDTH-1:0] shadow_state;

  typedef struct {
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic             chk_sh;
  } exp_t;

  exp_t             sb_q[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  logic [WIDTH-1:0] gen_state;
  int               exp_cnt;

  always #5 clk = ~clk;

  lfsr_checker #(
    .WIDTH(WIDTH), .LOCK_COUNT(8), .LOSS_COUNT(4), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .rst(rst), .resync(resync), .in_valid(in_valid), .in_bit(in_bit),
    .taps(taps), .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
    .shadow_state(shadow_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("locked", 32'(locked), 32'(e.locked));
        check("err_pulse", 32'(err_pulse), 32'(e.err_pulse));
        check("err_count", 32'(err_count), 32'(e.err_count));
        if (e.chk_sh) check("shadow_state", 32'(shadow_state), 32'd0);
      end
    end
  end

  task automatic step(input logic v, input logic b, input logic r, input logic rs,
                      input logic e_lock, input logic e_pulse, input int e_cnt,
                      input logic chk_sh);
    exp_t e;
    in_valid = v; in_bit = b; rst = r; resync = rs;
    @(posedge clk);
    e.locked = e_lock; e.err_pulse = e_pulse; e.err_count = ERR_W'(e_cnt); e.chk_sh = chk_sh;
    sb_q.push_back(e);
    #1;
  endtask

  // Independent generator model: fb from tapped bits, shifted in at bit 0, emitted as the stream bit.
  task automatic gen_bit(output logic b);
    logic fb;
    fb = ^(taps & gen_state);
    gen_state = {gen_state[WIDTH-2:0], fb};
    b = fb;
  endtask

  task automatic do_reset(input logic use_rst, input logic with_beat);
    logic b;
    b = 1'b0;
    if (with_beat) gen_bit(b);
    step(with_beat, b, use_rst, ~use_rst, 1'b0, 1'b0, 0, 1'b1);
    exp_cnt = 0;
  endtask

  task automatic relock();
    logic b;
    for (int j = 1; j <= 13; j++) begin
      gen_bit(b);
      step(1'b1, b, 1'b0, 1'b0, (j >= 13), 1'b0, exp_cnt, 1'b0);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : driver
    logic b, flip;
    taps = 5'b10100; gen_state = 5'b00001; exp_cnt = 0;
    rst = 1'b1; resync = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);

    // Clean lock: locked from the 13th beat on, no errors over 200 beats.
    for (int i = 1; i <= 200; i++) begin
      gen_bit(b);
      step(1'b1, b, 1'b0, 1'b0, (i >= 13), 1'b0, 0, 1'b0);
    end

    // Single inverted bit at beat 50.
    for (int i = 1; i <= 60; i++) begin
      gen_bit(b);
      if (i == 50) exp_cnt = 1;
      step(1'b1, b ^ (i == 50), 1'b0, 1'b0, 1'b1, (i == 50), exp_cnt, 1'b0);
    end

    // Loss of lock: four consecutive errors, then clean relock with count retained.
    do_reset(1'b0, 1'b0);
    relock();
    for (int i = 1; i <= 4; i++) begin
      gen_bit(b);
      exp_cnt++;
      step(1'b1, ~b, 1'b0, 1'b0, (i < 4), 1'b1, exp_cnt, 1'b0);
    end
    for (int j = 1; j <= 20; j++) begin
      gen_bit(b);
      step(1'b1, b, 1'b0, 1'b0, (j >= 13), 1'b0, exp_cnt, 1'b0);
    end

    // Mid-operation clear at err_count=3, first via resync then via rst; the beat that cycle is ignored.
    for (int u = 0; u < 2; u++) begin
      do_reset(1'b0, 1'b0);
      relock();
      for (int i = 1; i <= 8; i++) begin
        gen_bit(b);
        flip = ((i % 2) == 0) && (i <= 6);
        if (flip) exp_cnt++;
        step(1'b1, b ^ flip, 1'b0, 1'b0, 1'b1, flip, exp_cnt, 1'b0);
      end
      do_reset(u == 1, 1'b1);
      relock();
    end

    // Gapped stream 1-on/2-off: lock after 13 valid beats; error pulse only after a valid beat.
    do_reset(1'b0, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      gen_bit(b);
      flip = (k == 15);
      if (flip) exp_cnt++;
      step(1'b1, b ^ flip, 1'b0, 1'b0, (k >= 13), flip, exp_cnt, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, (k >= 13), 1'b0, exp_cnt, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, (k >= 13), 1'b0, exp_cnt, 1'b0);
    end

    // Saturation: alternating errors keep lock while the 3-bit counter pins at 7.
    for (int i = 1; i <= 20; i++) begin
      gen_bit(b);
      flip = (i % 2) == 1;
      if (flip && exp_cnt < 7) exp_cnt++;
      step(1'b1, b ^ flip, 1'b0, 1'b0, 1'b1, flip, exp_cnt, 1'b0);
    end

    // All-zero input never locks and leaves the shadow at zero.
    do_reset(1'b0, 1'b0);
    for (int i = 1; i <= 100; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Receive-side companion to the team's `lfsr` generator: consumes the serial bit stream the generator emits on `out`, one bit per `advance` beat.
- Self-synchronises a local shadow LFSR to the stream, declares lock, then counts bit errors against the predicted sequence.
- Sits on the sink end of PRBS/scrambler links, for BIST and link-integrity checking.

Parameters:
- WIDTH, 5: LFSR state width; must match the generator.
- LOCK_COUNT, 8: consecutive correct predictions required in VERIFY before asserting `locked`.
- LOSS_COUNT, 4: consecutive mismatches in LOCKED that force re-acquisition.
- ERR_W, 16: width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- resync  input  1  synchronous re-acquire request; same effect as rst on FSM and counters
- in_valid  input  1  qualifies `in_bit`; one stream bit per cycle with in_valid=1
- in_bit  input  1  received stream bit (generator `out`)
- taps  input  WIDTH  feedback tap mask, same encoding as the generator; held static while running
- locked  output  1  checker synchronised to the stream
- err_pulse  output  1  one-cycle pulse: the last valid bit mismatched while LOCKED
- err_count  output  ERR_W  saturating count of mismatches seen in LOCKED
- shadow_state  output  WIDTH  current shadow LFSR state, for debug

Behaviour:
- Stream model:
  - Each beat, the generator computes fb = XOR-reduce(taps & state).
  - It then updates state <= {state[WIDTH-2:0], fb}.
  - The stream bit for that beat is the new state[0], i.e. fb.
  - The checker predicts pred = XOR-reduce(taps & shadow).
- Only cycles with in_valid=1 change state; other cycles hold everything and keep err_pulse=0.
- FSM states: SEED, VERIFY, LOCKED.
- SEED:
  - Shadow <= {shadow[WIDTH-2:0], in_bit}; a fill counter increments.
  - After WIDTH beats, go to VERIFY if shadow is non-zero.
  - If shadow is all-zero, restart the fill (the zero state is not lockable).
- VERIFY:
  - Shadow loads in_bit, as in SEED.
  - in_bit == pred increments the match counter.
  - On the LOCK_COUNT-th consecutive match, go to LOCKED; `locked`=1 from the next cycle.
  - Any mismatch returns to SEED with the fill counter cleared; shadow keeps its loaded value.
- LOCKED:
  - Shadow advances with pred, never in_bit, so a single errored bit does not corrupt the prediction.
  - Mismatch: err_pulse=1 next cycle; err_count+1, saturating at 2^ERR_W-1; loss counter+1.
  - Match: loss counter clears.
  - Loss counter reaching LOSS_COUNT: go to SEED and drop `locked` next cycle. err_count is retained; the LOSS_COUNT-th error is still counted.
- All outputs are registered; latency from sampled beat to locked/err_pulse/err_count update is 1 cycle.
- rst or resync (rst has priority; identical effect):
  - FSM to SEED; shadow=0; fill, match and loss counters=0.
  - locked=0, err_pulse=0, err_count=0.
  - Takes effect on the same edge, ignoring any in_valid beat that cycle, including mid-lock.
- Changing `taps` while locked is unsupported; the required recovery is resync.

Decomposition:
- Package `lfsr_pkg`:
  - FSM state enum (SEED, VERIFY, LOCKED).
  - Function lfsr_next(state, taps) returning {next_state, fb}.
  - The generator and the checker both use this function so their polynomial semantics cannot diverge.
- One sub-module is natural: `sat_counter` (parameterised width; inc, clr, saturate), used for err_count.
- The fill, match and loss counters are small and stay inline.

Test Plan:
- Clean lock: generator with initial_state=5'b00001, taps=5'b10100 advancing every cycle, in_valid=1 → locked=1 exactly one cycle after the 13th beat (WIDTH+LOCK_COUNT); err_count=0 after 200 beats.
- Single bit error: once locked, invert beat 50 → err_pulse high for exactly one cycle on the following cycle; err_count=1; locked stays 1; no further errors.
- Loss of lock: once locked, invert 4 consecutive beats → err_count=4, locked=0 after the 4th; clean stream resumes → relock 13 valid beats later; err_count still 4.
- Gapped stream: drive in_valid with a 1-on/2-off pattern → lock after 13 valid beats (39 cycles); no err_pulse on idle cycles.
- All-zero input: in_bit=0 for 100 beats → locked never asserts; shadow_state=0.
- Reset mid-operation: with locked=1 and err_count=3, pulse resync for one cycle → next cycle locked=0, err_count=0, shadow_state=0; clean stream relocks after 13 beats. Repeat the same sequence using rst and expect identical results.
- Saturation: set ERR_W=3 and feed a random stream after lock, or force errors → err_count sticks at 7.
